// File: rtl/oam_dma_engine.sv
// oam_dma_engine: Game Boy OAM DMA, copies XFER_LEN bytes from page {src_hi,8'h00} into OAM
//
// Optional feature macro: OAM_DMA_READBACK_EN
//   defined   - O_REG_DATA returns the raw last byte written to FF46 (reset 8'h00)
//   undefined - O_REG_DATA is constant 8'hFF (write-only register)
//
// Ports:
//   I_CLK       system clock, all state on posedge
//   I_RESET_N   asynchronous active-low reset
//   I_REG_WE    CPU register write strobe (one cycle)
//   I_REG_ADDR  CPU register address, decoded against 16'hFF46
//   I_REG_DATA  CPU write data (source high byte)
//   O_REG_DATA  FF46 readback
//   O_SRC_EN    source read enable
//   O_SRC_ADDR  source read address {src_hi, idx}
//   I_SRC_DATA  source read data, valid READ_LATENCY cycles after O_SRC_EN
//   O_OAM_EN    OAM port enable
//   O_OAM_WE    OAM write enable
//   O_OAM_ADDR  OAM byte index
//   O_OAM_DIN   OAM write data
//   O_BUSY      transfer in progress
module oam_dma_engine #(
   parameter int READ_LATENCY = 1,
   parameter int XFER_LEN     = 160
) (
   input  logic        I_CLK,
   input  logic        I_RESET_N,
   input  logic        I_REG_WE,
   input  logic [15:0] I_REG_ADDR,
   input  logic [7:0]  I_REG_DATA,
   output logic [7:0]  O_REG_DATA,
   output logic        O_SRC_EN,
   output logic [15:0] O_SRC_ADDR,
   input  logic [7:0]  I_SRC_DATA,
   output logic        O_OAM_EN,
   output logic        O_OAM_WE,
   output logic [7:0]  O_OAM_ADDR,
   output logic [7:0]  O_OAM_DIN,
   output logic        O_BUSY
);
   typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_WRITE} state_t;
   localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY - 1);
   localparam logic [7:0] IDX_LAST = 8'(XFER_LEN - 1);
   state_t     r_state;
   logic [7:0] r_idx;
   logic [7:0] r_src_hi;
   logic [7:0] r_data_q;
   logic [1:0] r_wait;
   logic       r_busy;
   logic       w_start;
   logic       w_rd;
   logic       w_wr;
   logic [7:0] w_src_hi;
   assign w_start  = I_REG_WE && (I_REG_ADDR == 16'hFF46);
   // echo RAM fold: E0-FF map onto C0-DF
   assign w_src_hi = (I_REG_DATA > 8'hDF) ? I_REG_DATA - 8'h20 : I_REG_DATA;
   assign w_rd     = (r_state == S_READ);
   assign w_wr     = (r_state == S_WRITE);
   // a start/restart write overrides whatever state the transfer is in;
   // a WRITE cycle coinciding with it still drives OAM since outputs decode the current state
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N) begin
         r_state  <= S_IDLE;
         r_idx    <= 8'h00;
         r_src_hi <= 8'h00;
         r_data_q <= 8'h00;
         r_wait   <= 2'd0;
         r_busy   <= 1'b0;
      end else if (w_start) begin
         r_src_hi <= w_src_hi;
         r_idx    <= 8'h00;
         r_wait   <= 2'd0;
         r_state  <= S_READ;
         r_busy   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: ;
            S_READ: begin
               r_wait  <= 2'd0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wait == LAT_LAST) begin
                  r_data_q <= I_SRC_DATA;
                  r_state  <= S_WRITE;
               end else begin
                  r_wait <= r_wait + 2'd1;
               end
            end
            S_WRITE: begin
               if (r_idx == IDX_LAST) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_idx   <= r_idx + 8'd1;
                  r_state <= S_READ;
               end
            end
         endcase
      end
   end
   assign O_SRC_EN   = w_rd;
   assign O_SRC_ADDR = w_rd ? {r_src_hi, r_idx} : 16'h0000;
   assign O_OAM_EN   = w_wr;
   assign O_OAM_WE   = w_wr;
   assign O_OAM_ADDR = w_wr ? r_idx : 8'h00;
   assign O_OAM_DIN  = r_data_q;
   assign O_BUSY     = r_busy;
`ifdef OAM_DMA_READBACK_EN
   logic [7:0] r_reg_data;
   always_ff @(posedge I_CLK or negedge I_RESET_N) begin
      if (!I_RESET_N)
         r_reg_data <= 8'h00;
      else if (w_start)
         r_reg_data <= I_REG_DATA;
   end
   assign O_REG_DATA = r_reg_data;
`else
   assign O_REG_DATA = 8'hFF;
`endif
endmodule

// File: tb/tb_oam_dma_engine.sv
// tb_oam_dma_engine: directed scoreboard bench for oam_dma_engine (default build and L=3/len=4 build)
module tb_oam_dma_engine;
`ifdef OAM_DMA_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        we = 1'b0, we2 = 1'b0;
   logic [15:0] raddr = 16'h0, raddr2 = 16'h0;
   logic [7:0]  wdata = 8'h0, wdata2 = 8'h0;
   logic [7:0]  reg_rd, reg_rd2;
   logic        src_en, src_en2;
   logic [15:0] src_addr, src_addr2;
   logic [7:0]  src_data = 8'h0;
   logic [7:0]  p0 = 8'h0, p1 = 8'h0, p2 = 8'h0;
   logic        oam_en, oam_en2, oam_we, oam_we2, busy, busy2;
   logic [7:0]  oam_addr, oam_addr2, oam_din, oam_din2;
   always #5 clk = ~clk;

   oam_dma_engine u_dut (
      .I_CLK(clk), .I_RESET_N(rst_n), .I_REG_WE(we), .I_REG_ADDR(raddr), .I_REG_DATA(wdata),
      .O_REG_DATA(reg_rd), .O_SRC_EN(src_en), .O_SRC_ADDR(src_addr), .I_SRC_DATA(src_data),
      .O_OAM_EN(oam_en), .O_OAM_WE(oam_we), .O_OAM_ADDR(oam_addr), .O_OAM_DIN(oam_din), .O_BUSY(busy));

   oam_dma_engine #(.READ_LATENCY(3), .XFER_LEN(4)) u_lat (
      .I_CLK(clk), .I_RESET_N(rst_n), .I_REG_WE(we2), .I_REG_ADDR(raddr2), .I_REG_DATA(wdata2),
      .O_REG_DATA(reg_rd2), .O_SRC_EN(src_en2), .O_SRC_ADDR(src_addr2), .I_SRC_DATA(p2),
      .O_OAM_EN(oam_en2), .O_OAM_WE(oam_we2), .O_OAM_ADDR(oam_addr2), .O_OAM_DIN(oam_din2), .O_BUSY(busy2));

   function automatic logic [7:0] f(input logic [15:0] a);
      return a[7:0] ^ 8'h5A ^ a[15:8] ^ 8'hC1;
   endfunction

   // source memories: 1-cycle bram for u_dut, 3-stage pipeline for u_lat
   always @(posedge clk) begin
      if (src_en) src_data <= f(src_addr);
      if (src_en2) p0 <= f(src_addr2);
      p1 <= p0;
      p2 <= p1;
   end

   int n_assert = 0, n_fail = 0;
   logic [15:0] sb[$], sb2[$];
   logic [7:0]  oam[256];
   int wr_n, busy_n, rises, src_n, src_bad, overlap, wr2_n, busy2_n;
   logic [15:0] src_first, src_last;
   logic [7:0]  exp_hi;
   logic        busy_q = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // one cycle: sample both DUTs at the negedge, then return so inputs can be driven
   task automatic tick();
      @(negedge clk);
      if (oam_we) begin
         wr_n++;
         oam[oam_addr] = oam_din;
         chk("sb_nonempty", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) chk("oam_write", {oam_addr, oam_din}, sb.pop_front());
      end
      if (busy) busy_n++;
      if (busy && !busy_q) rises++;
      busy_q = busy;
      if (src_en) begin
         if (src_n == 0) src_first = src_addr;
         src_last = src_addr;
         src_n++;
         if (src_addr[15:8] != exp_hi || src_addr[7:0] > 8'd159) src_bad++;
      end
      if ((src_en && oam_we) || (oam_en != oam_we)) overlap++;
      if (oam_we2) begin
         wr2_n++;
         chk("sb2_nonempty", 32'(sb2.size() != 0), 1);
         if (sb2.size() != 0) chk("lat_write", {oam_addr2, oam_din2}, sb2.pop_front());
      end
      if (busy2) busy2_n++;
   endtask

   task automatic begin_phase(input logic [7:0] hi);
      wr_n = 0; busy_n = 0; rises = 0; src_n = 0; src_bad = 0; overlap = 0; exp_hi = hi;
   endtask

   task automatic push(input logic [7:0] hi, input int len);
      for (int i = 0; i < len; i++) sb.push_back({8'(i), f({hi, 8'(i)})});
   endtask

   task automatic fw(input logic [15:0] a, input logic [7:0] d);
      we = 1'b1; raddr = a; wdata = d;
      tick();
      we = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int c = 0;
      while (busy && c < maxc) begin
         tick();
         c++;
      end
      chk("idle_timeout", {31'd0, busy}, 0);
   endtask

   task automatic xfer(input string tag, input logic [7:0] wr_val, input logic [7:0] hi);
      begin_phase(hi);
      push(hi, 160);
      fw(16'hFF46, wr_val);
      chk({tag, "_readback"}, reg_rd, RB ? wr_val : 8'hFF);
      wait_idle(600);
      chk({tag, "_writes"}, wr_n, 160);
      chk({tag, "_busy_cycles"}, busy_n, 480);
      chk({tag, "_busy_rises"}, rises, 1);
      chk({tag, "_sb_left"}, sb.size(), 0);
      chk({tag, "_overlap"}, overlap, 0);
      chk({tag, "_src_bad"}, src_bad, 0);
      chk({tag, "_src_first"}, src_first, {hi, 8'h00});
      chk({tag, "_src_last"}, src_last, {hi, 8'h9F});
   endtask

   initial begin
      int wr_before;
      begin_phase(8'h00);
      wr2_n = 0; busy2_n = 0;
      repeat (3) tick();
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_src_en", {31'd0, src_en}, 0);
      chk("rst_oam_en", {31'd0, oam_en}, 0);
      chk("rst_oam_we", {31'd0, oam_we}, 0);
      chk("rst_src_addr", src_addr, 0);
      chk("rst_oam_addr", oam_addr, 0);
      chk("rst_oam_din", oam_din, 0);
      chk("rst_reg_rd", reg_rd, RB ? 8'h00 : 8'hFF);
      rst_n = 1'b1;
      repeat (2) tick();

      xfer("basic", 8'hC1, 8'hC1);
      xfer("echo", 8'hE3, 8'hC3);

      // restart 80 -> 90 fifty cycles into the transfer
      begin_phase(8'h80);
      push(8'h80, 160);
      fw(16'hFF46, 8'h80);
      repeat (49) tick();
      we = 1'b1; raddr = 16'hFF46; wdata = 8'h90;
      sb.delete();
      push(8'h90, 160);
      wr_before = wr_n;
      src_n = 0;
      exp_hi = 8'h90;
      tick();
      we = 1'b0;
      chk("restart_first_src", src_first, 16'h9000);
      wait_idle(600);
      chk("restart_writes", wr_n - wr_before, 160);
      chk("restart_busy_rises", rises, 1);
      chk("restart_busy_cycles", busy_n, 530);
      chk("restart_sb_left", sb.size(), 0);
      chk("restart_src_bad", src_bad, 0);
      for (int i = 0; i < 16; i++) chk("restart_oam", oam[i], f({8'h90, 8'(i)}));

      // async reset 200 cycles into a transfer, between clock edges
      begin_phase(8'hC1);
      push(8'hC1, 160);
      fw(16'hFF46, 8'hC1);
      repeat (199) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("areset_busy", {31'd0, busy}, 0);
      chk("areset_oam_we", {31'd0, oam_we}, 0);
      chk("areset_src_en", {31'd0, src_en}, 0);
      sb.delete();
      wr_before = wr_n;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      chk("areset_no_writes", wr_n - wr_before, 0);
      chk("areset_idle", {31'd0, busy}, 0);
      chk("areset_reg_rd", reg_rd, RB ? 8'h00 : 8'hFF);
      xfer("post_reset", 8'hC1, 8'hC1);

      // address decode: FF47 must be ignored
      begin_phase(8'hC0);
      fw(16'hFF47, 8'hC0);
      repeat (10) tick();
      chk("decode_busy_cycles", busy_n, 0);
      chk("decode_writes", wr_n, 0);
      chk("decode_reads", src_n, 0);
      chk("decode_reg_rd", reg_rd, RB ? 8'hC1 : 8'hFF);

      // latency sweep on the READ_LATENCY=3, XFER_LEN=4 instance
      wr2_n = 0; busy2_n = 0;
      for (int i = 0; i < 4; i++) sb2.push_back({8'(i), f({8'hD0, 8'(i)})});
      we2 = 1'b1; raddr2 = 16'hFF46; wdata2 = 8'hD0;
      tick();
      we2 = 1'b0;
      for (int c = 0; c < 100 && busy2; c++) tick();
      chk("lat_idle_timeout", {31'd0, busy2}, 0);
      chk("lat_writes", wr2_n, 4);
      chk("lat_busy_cycles", busy2_n, 20);
      chk("lat_sb_left", sb2.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
